// File: rtl/dpi_sync_regen_if.sv
// DPI-in / HDMI-encoder-out signal bundle for the sync regenerator.
// Carries no state, so it adds no latency.
// There is no backpressure: pixels stream at the video clock rate.
interface dpi_sync_regen_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] rgb_in;
    logic              vsync_in;
    logic [DATA_W-1:0] rgb_out;
    logic              hsync;
    logic              vsync;
    logic              active;
    logic [15:0]       pixel_count;
    logic [15:0]       line_count;
    logic              frame_start;
    logic              locked;

    // Pixel source side
    modport master (
        output rgb_in, vsync_in,
        input  rgb_out, hsync, vsync, active, pixel_count, line_count,
               frame_start, locked
    );

    // Regenerator side
    modport slave (
        input  rgb_in, vsync_in,
        output rgb_out, hsync, vsync, active, pixel_count, line_count,
               frame_start, locked
    );
endinterface

// File: rtl/dpi_sync_regen.sv
// Regenerates HDMI timing from a free-running raster that is phase-locked to DPI vsync_in.
// All outputs are registered, so each one lags the raster counters and rgb_in by one cycle.
// There is no backpressure: the block accepts one pixel on every clk_video cycle.
module dpi_sync_regen #(
    parameter int DATA_W      = 24,
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_ACTIVE    = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter bit VS_IN_POL   = 1'b1,
    parameter int V_RESYNC    = V_ACTIVE + V_FP,
    parameter int LOCK_FRAMES = 3,
    parameter bit BLANK_ZERO  = 1'b1
) (
    input  logic            clk_video,
    input  logic            reset_n,
    dpi_sync_regen_if.slave dpi
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_RS   = 16'(V_RESYNC);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } lock_state_t;

    lock_state_t state, state_nxt;

    logic [15:0]       h_cnt, v_cnt;
    logic [15:0]       h_adv, v_adv;
    logic              h_wrap, v_wrap, frame_wrap;
    logic              vs_r, vs_edge, match, reload;
    logic [7:0]        match_cnt, match_nxt;
    logic [1:0]        nowrap_cnt, nowrap_nxt;
    logic              active_c, hs_c, vs_c;
    logic [DATA_W-1:0] rgb_c;

    // Free-running raster position for the next cycle, ignoring any resync reload.
    assign h_wrap     = (h_cnt == H_LAST);
    assign v_wrap     = (v_cnt == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;
    assign h_adv      = h_wrap ? 16'd0 : h_cnt + 16'd1;
    assign v_adv      = !h_wrap ? v_cnt : (v_wrap ? 16'd0 : v_cnt + 16'd1);

    // A leading edge of vsync_in matches when the raster is already on course to hit the resync point.
    assign vs_edge = (dpi.vsync_in == VS_IN_POL) && (vs_r != VS_IN_POL);
    assign match   = (h_adv == 16'd0) && (v_adv == V_RS);

    // Output decode of the current raster position.
    assign active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_c     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign rgb_c    = (active_c || !BLANK_ZERO) ? dpi.rgb_in : '0;

    // Lock FSM next state. An edge always wins over the missing-vsync timeout.
    always_comb begin
        state_nxt  = state;
        match_nxt  = match_cnt;
        nowrap_nxt = nowrap_cnt;
        reload     = 1'b0;
        if (vs_edge) begin
            nowrap_nxt = 2'd0;
            unique case (state)
                ST_FREE: begin
                    reload    = 1'b1;
                    match_nxt = 8'd0;
                    state_nxt = ST_ACQ;
                end
                ST_ACQ: begin
                    if (match) begin
                        match_nxt = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 >= LOCK_N) begin
                            state_nxt = ST_LOCK;
                        end
                    end else begin
                        reload    = 1'b1;
                        match_nxt = 8'd0;
                    end
                end
                ST_LOCK: begin
                    if (!match) begin
                        reload    = 1'b1;
                        match_nxt = 8'd0;
                        state_nxt = ST_ACQ;
                    end
                end
                default: begin
                    state_nxt = ST_FREE;
                end
            endcase
        end else if (frame_wrap) begin
            // Second frame without a vsync_in edge means the source has gone away.
            if (state != ST_FREE && nowrap_cnt == 2'd1) begin
                state_nxt  = ST_FREE;
                match_nxt  = 8'd0;
                nowrap_nxt = 2'd0;
            end else if (nowrap_cnt != 2'd3) begin
                nowrap_nxt = nowrap_cnt + 2'd1;
            end
        end
    end

    // Raster counters, vsync_in history and lock FSM state.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt      <= 16'd0;
            v_cnt      <= 16'd0;
            vs_r       <= ~VS_IN_POL;
            state      <= ST_FREE;
            match_cnt  <= 8'd0;
            nowrap_cnt <= 2'd0;
        end else begin
            vs_r       <= dpi.vsync_in;
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            nowrap_cnt <= nowrap_nxt;
            if (reload) begin
                h_cnt <= 16'd0;
                v_cnt <= V_RS;
            end else begin
                h_cnt <= h_adv;
                v_cnt <= v_adv;
            end
        end
    end

    // Registered outputs, aligned with the pixel that was presented on rgb_in.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            dpi.rgb_out     <= '0;
            dpi.active      <= 1'b0;
            dpi.hsync       <= ~HS_POL;
            dpi.vsync       <= ~VS_POL;
            dpi.pixel_count <= 16'd0;
            dpi.line_count  <= 16'd0;
            dpi.frame_start <= 1'b0;
            dpi.locked      <= 1'b0;
        end else begin
            dpi.rgb_out     <= rgb_c;
            dpi.active      <= active_c;
            dpi.hsync       <= hs_c ? HS_POL : ~HS_POL;
            dpi.vsync       <= vs_c ? VS_POL : ~VS_POL;
            dpi.pixel_count <= h_cnt;
            dpi.line_count  <= v_cnt;
            dpi.frame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
            dpi.locked      <= (state_nxt == ST_LOCK);
        end
    end

endmodule

// File: tb/tb_dpi_sync_regen.sv
// Directed bench for dpi_sync_regen on a 16x8 raster with a behavioural raster/lock model.
// The model predicts the registered outputs one cycle ahead; a negedge process compares.
// There is no backpressure; stimulus is driven 1 ns after each rising edge.
module tb_dpi_sync_regen;

    logic clk_video = 1'b0;
    logic reset_n;

    dpi_sync_regen_if #(.DATA_W(8)) dpi ();

    dpi_sync_regen #(
        .DATA_W(8),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .VS_IN_POL(1'b1),
        .V_RESYNC(5), .LOCK_FRAMES(3), .BLANK_ZERO(1'b1)
    ) dut (
        .clk_video(clk_video),
        .reset_n(reset_n),
        .dpi(dpi)
    );

    always #5 clk_video = ~clk_video;

    int n_chk  = 0;
    int n_fail = 0;
    int n_prt  = 0;

    // ------------------------------------------------------------------
    // Behavioural model: raster position as one number 0..127
    // (line*16 + pixel), resync point is line 5 pixel 0 = 80.
    // ------------------------------------------------------------------
    int         m_pos, m_mc, m_nowrap, m_nxt, m_h, m_v;
    bit         m_tracking, m_locked, m_vs_prev, m_edge;
    logic [7:0] e_rgb;
    logic       e_hs, e_vs, e_act, e_fs, e_lock;
    logic [15:0] e_px, e_ln;

    always @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = 0; m_mc = 0; m_nowrap = 0;
            m_tracking = 0; m_locked = 0; m_vs_prev = 0;
            e_rgb = 8'd0; e_hs = 0; e_vs = 0; e_act = 0; e_fs = 0; e_lock = 0;
            e_px = 16'd0; e_ln = 16'd0;
        end else begin
            m_h   = m_pos % 16;
            m_v   = m_pos / 16;
            e_act = (m_h < 8) && (m_v < 4);
            e_hs  = (m_h == 10) || (m_h == 11);
            e_vs  = (m_v == 5);
            e_px  = 16'(m_h);
            e_ln  = 16'(m_v);
            e_fs  = (m_pos == 0);
            e_rgb = e_act ? dpi.rgb_in : 8'd0;

            m_edge    = dpi.vsync_in && !m_vs_prev;
            m_vs_prev = dpi.vsync_in;
            m_nxt     = (m_pos + 1) % 128;
            if (m_edge) begin
                m_nowrap = 0;
                if (m_tracking && m_nxt == 80) begin
                    if (!m_locked) begin
                        m_mc++;
                        if (m_mc == 3) m_locked = 1;
                    end
                end else begin
                    m_nxt = 80; m_mc = 0; m_tracking = 1; m_locked = 0;
                end
            end else if (m_pos == 127) begin
                m_nowrap++;
                if (m_nowrap == 2 && m_tracking) begin
                    m_tracking = 0; m_locked = 0;
                end
            end
            m_pos  = m_nxt;
            e_lock = m_locked;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_video) begin
        n_chk++;
        if (dpi.rgb_out !== e_rgb || dpi.hsync !== e_hs || dpi.vsync !== e_vs ||
            dpi.active !== e_act || dpi.pixel_count !== e_px || dpi.line_count !== e_ln ||
            dpi.frame_start !== e_fs || dpi.locked !== e_lock) begin
            n_fail++;
            if (n_prt < 30) begin
                n_prt++;
                $display("FAIL cycle_cmp t=%0t got rgb=%h hs=%b vs=%b de=%b px=%0d ln=%0d fs=%b lk=%b want rgb=%h hs=%b vs=%b de=%b px=%0d ln=%0d fs=%b lk=%b",
                         $time, dpi.rgb_out, dpi.hsync, dpi.vsync, dpi.active, dpi.pixel_count,
                         dpi.line_count, dpi.frame_start, dpi.locked, e_rgb, e_hs, e_vs, e_act,
                         e_px, e_ln, e_fs, e_lock);
            end
        end
    end

    // ------------------------------------------------------------------
    // Literal checks and stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_video);
        #1;
        dpi.rgb_in = dpi.rgb_in + 8'd3;
    endtask

    // One rising vsync_in edge, then hold the remaining gap so edges are 'gap' cycles apart.
    task automatic edge_then(input int gap);
        dpi.vsync_in = 1'b1;
        repeat (4) cyc();
        dpi.vsync_in = 1'b0;
        repeat (gap - 4) cyc();
    endtask

    int         n_act, n_hs, n_vs, n_fs, n_lk;
    logic [7:0] rgb_before;

    initial begin
        reset_n      = 1'b0;
        dpi.vsync_in = 1'b0;
        dpi.rgb_in   = 8'd0;
        repeat (3) cyc();
        chk("rst_locked", int'(dpi.locked), 0);
        chk("rst_hsync",  int'(dpi.hsync), 0);
        chk("rst_active", int'(dpi.active), 0);
        chk("rst_pixel",  int'(dpi.pixel_count), 0);
        chk("rst_fs",     int'(dpi.frame_start), 0);

        // Free-run frame with no vsync_in
        reset_n = 1'b1;
        n_act = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_lk = 0;
        for (int i = 0; i < 128; i++) begin
            rgb_before = dpi.rgb_in;
            cyc();
            n_act += int'(dpi.active);
            n_hs  += int'(dpi.hsync);
            n_vs  += int'(dpi.vsync);
            n_fs  += int'(dpi.frame_start);
            n_lk  += int'(dpi.locked);
            if (i == 0)  chk("first_fs", int'(dpi.frame_start), 1);
            if (i == 3)  chk("rgb_pass", int'(dpi.rgb_out), int'(rgb_before));
            if (i == 9)  chk("rgb_blank", int'(dpi.rgb_out), 0);
            if (i == 10) chk("hs_at_10", int'(dpi.hsync), 1);
            if (i == 12) chk("hs_at_12", int'(dpi.hsync), 0);
            if (i == 80) chk("vs_line5", int'(dpi.vsync), 1);
        end
        chk("active_cnt", n_act, 32);
        chk("hsync_cnt",  n_hs, 16);
        chk("vsync_cnt",  n_vs, 16);
        chk("fs_cnt",     n_fs, 1);
        chk("free_lock",  n_lk, 0);
        cyc();
        chk("period_fs",  int'(dpi.frame_start), 1);

        // First edge reloads the raster to line 5 pixel 0
        dpi.vsync_in = 1'b1;
        cyc();
        cyc();
        chk("reload_px", int'(dpi.pixel_count), 0);
        chk("reload_ln", int'(dpi.line_count), 5);
        chk("acq_lock0", int'(dpi.locked), 0);
        cyc();
        cyc();
        dpi.vsync_in = 1'b0;
        repeat (124) cyc();
        edge_then(128);
        edge_then(128);
        chk("lock_after2", int'(dpi.locked), 0);
        edge_then(128);
        chk("lock_after3", int'(dpi.locked), 1);
        chk("lock_px", int'(dpi.pixel_count), 14);
        chk("lock_ln", int'(dpi.line_count), 4);

        // Early edge while locked
        edge_then(125);
        chk("still_lock", int'(dpi.locked), 1);
        dpi.vsync_in = 1'b1;
        cyc();
        chk("early_unlock", int'(dpi.locked), 0);
        chk("early_px", int'(dpi.pixel_count), 12);
        cyc();
        chk("early_rl_px", int'(dpi.pixel_count), 0);
        chk("early_rl_ln", int'(dpi.line_count), 5);
        cyc();
        cyc();
        dpi.vsync_in = 1'b0;
        repeat (124) cyc();
        edge_then(128);
        edge_then(128);
        chk("relock_2", int'(dpi.locked), 0);
        edge_then(128);
        chk("relock_3", int'(dpi.locked), 1);

        // vsync_in disappears: unlock on the second edgeless frame wrap
        repeat (48) cyc();
        chk("to_hold", int'(dpi.locked), 1);
        cyc();
        chk("to_unlock", int'(dpi.locked), 0);
        chk("to_px", int'(dpi.pixel_count), 15);
        chk("to_ln", int'(dpi.line_count), 7);
        cyc();
        chk("to_wrap_fs", int'(dpi.frame_start), 1);

        // Relock, then reset in mid-line
        repeat (4) edge_then(128);
        chk("pre_rst_lock", int'(dpi.locked), 1);
        repeat (5) cyc();
        reset_n = 1'b0;
        #1;
        chk("arst_locked", int'(dpi.locked), 0);
        chk("arst_px",     int'(dpi.pixel_count), 0);
        chk("arst_ln",     int'(dpi.line_count), 0);
        chk("arst_active", int'(dpi.active), 0);
        chk("arst_rgb",    int'(dpi.rgb_out), 0);
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        chk("restart_fs", int'(dpi.frame_start), 1);
        chk("restart_px", int'(dpi.pixel_count), 0);
        chk("restart_lk", int'(dpi.locked), 0);
        edge_then(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpi_sync_regen.md
DPI_SYNC_REGEN -- requirements
Module: dpi_sync_regen

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DATA_W 24, pixel data width
  H_ACTIVE 1280 / H_FP 110 / H_SYNC 40 / H_BP 220, horizontal timing in pixels
  V_ACTIVE 720 / V_FP 5 / V_SYNC 5 / V_BP 20, vertical timing in lines
  HS_POL 1 / VS_POL 1, output sync active level
  VS_IN_POL 1, vsync_in active level
  V_RESYNC V_ACTIVE+V_FP, line loaded on resync
  LOCK_FRAMES 3, consecutive matching frames needed to lock
  BLANK_ZERO 1, force rgb_out to 0 outside active
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk_video  in  1  pixel clock
  reset_n  in  1  asynchronous, active-low reset
  rgb_in  in  DATA_W  DPI pixel data
  vsync_in  in  1  DPI vsync
  rgb_out  out  DATA_W  aligned pixel data to the HDMI encoder
  hsync  out  1  regenerated hsync
  vsync  out  1  regenerated vsync
  active  out  1  data-enable
  pixel_count  out  16  horizontal position
  line_count  out  16  vertical position
  frame_start  out  1  one-cycle pulse at pixel 0, line 0
  locked  out  1  timing locked to vsync_in

Function
REQ-003 SHALL derive H_TOTAL = sum of H params, V_TOTAL = sum of V params; h_cnt runs 0..H_TOTAL-1, v_cnt runs 0..V_TOTAL-1; v_cnt increments when h_cnt wraps; both wrap to 0 together at the end of a frame.
REQ-004 SHALL drive active high iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-005 SHALL assert hsync (level HS_POL) iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and vsync (level VS_POL) iff v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); both are inactive otherwise.
REQ-006 SHALL register all outputs; each output reflects h_cnt/v_cnt and rgb_in of the previous cycle (1-cycle latency).
REQ-007 SHALL set rgb_out = rgb_in when active; when inactive, rgb_out = 0 if BLANK_ZERO=1, else rgb_in.
REQ-008 SHALL register vsync_in once (vs_r); edge = vsync_in at VS_IN_POL while vs_r is not at VS_IN_POL.
REQ-009 SHALL define match as: at an edge cycle, the next counter value (without reload) equals h=0, v=V_RESYNC.
REQ-010 SHALL implement lock FSM states FREE, ACQ, LOCK, with locked=1 only in LOCK.
REQ-011 FREE: on edge, reload counters (h=0, v=V_RESYNC next cycle), clear match_cnt, go to ACQ.
REQ-012 ACQ: on edge with match, increment match_cnt; on reaching LOCK_FRAMES, go to LOCK.
REQ-013 ACQ: on edge without match, reload counters, clear match_cnt, stay in ACQ.
REQ-014 LOCK: on edge with match, stay in LOCK (no reload).
REQ-015 LOCK: on edge without match, reload counters, clear match_cnt, go to ACQ (locked falls the next cycle).
REQ-016 SHALL count frame wraps with no edge since the last edge; at the 2nd such wrap in ACQ or LOCK, go to FREE. Counters keep free-running in all states.
REQ-017 SHALL give edge precedence over timeout when both occur in the same cycle.
REQ-018 SHALL pulse frame_start for one cycle, coincident with output pixel_count=0, line_count=0.

Reset
REQ-019 While reset_n=0, asynchronously: h_cnt=v_cnt=0, vs_r=~VS_IN_POL, state FREE, match_cnt=0, rgb_out=0, active=0, frame_start=0, locked=0, hsync=~HS_POL, vsync=~VS_POL, pixel_count=line_count=0.
REQ-020 Reset asserted mid-frame or mid-lock SHALL abort immediately; after release, counting starts from 0 and the FSM is in FREE.

Verification
Bench parameters: H 8/2/2/4 (H_TOTAL=16), V 4/1/1/2 (V_TOTAL=8), V_RESYNC=5, LOCK_FRAMES=3, DATA_W=8.
REQ-021 No vsync_in, free-run -> active for 8 of every 16 cycles on lines 0-3; hsync high at h=10,11; vsync high on line 5; frame period 128 cycles; locked=0.
REQ-022 vsync_in edge every 128 cycles -> first edge reloads counters (line_count=5, pixel_count=0 one cycle later); locked=1 after the 3rd matching edge.
REQ-023 Locked, then one edge arrives 3 cycles early -> counters reload, locked=0 the next cycle, state ACQ; relock after 3 matching edges.
REQ-024 Locked, then vsync_in held low -> locked=0 at the 2nd frame wrap without an edge; counters continue without a glitch.
REQ-025 rgb_in = h_cnt ramp -> rgb_out equals rgb_in delayed 1 cycle during active and 0 when blanked; frame_start is a single pulse at (0,0).
REQ-026 reset_n pulsed low while locked mid-line -> all outputs hold reset values immediately; restart from (0,0) in FREE.
